// File: rtl/recover_2n_fft_pkg.sv
// Shared constants, twiddle entry type and quarter-wave twiddle ROM contents
// for the real-FFT recombination stage.
package recover_2n_fft_pkg;

    localparam int unsigned N_LANES   = 4;
    localparam int unsigned OUT_WIDTH = 32;
    localparam int unsigned LATENCY   = 3;
    localparam int unsigned ROM_WIDTH = 16;
    localparam int          ROM_MAX   = 32767;
    localparam real         Q15_SCALE = 32768.0;
    localparam real         PI        = 3.14159265358979323846;

    // One quarter-wave table entry: re = cos, im = sin, both Q1.15.
    typedef struct packed {
        logic signed [ROM_WIDTH-1:0] re;
        logic signed [ROM_WIDTH-1:0] im;
    } cplx_t;

    // Values are non-negative on the first quadrant, so +0.5 then truncate rounds.
    function automatic logic signed [ROM_WIDTH-1:0] q15_round(input real v);
        int r;
        r = $rtoi(v * Q15_SCALE + 0.5);
        if (r > ROM_MAX) begin
            r = ROM_MAX;
        end
        return ROM_WIDTH'(r);
    endfunction

    // Entry m of a quarter-wave table with 'depth' entries (full circle = 4*depth).
    function automatic cplx_t rom_entry(input int unsigned m, input int unsigned depth);
        cplx_t e;
        real   ang;
        ang  = 2.0 * PI * real'(m) / (4.0 * real'(depth));
        e.re = q15_round($cos(ang));
        e.im = q15_round($sin(ang));
        return e;
    endfunction

endpackage

// File: rtl/recover_2n_fft_lane.sv
// One output bin per clock: twiddle lookup, complex multiply by X2, rounding
// shift and accumulation onto X1. Two register stages (multiply, then add).
module recover_lane
    import recover_2n_fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 27,
    parameter int unsigned TWID_WIDTH = 16,
    parameter int unsigned LSB_CUTOFF = 12,
    parameter int unsigned SHIFT      = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [LSB_CUTOFF:0]          k,
    input  logic signed [DATA_WIDTH-1:0] x1_r,
    input  logic signed [DATA_WIDTH-1:0] x1_i,
    input  logic signed [DATA_WIDTH-1:0] x2_r,
    input  logic signed [DATA_WIDTH-1:0] x2_i,
    input  cplx_t                        rom [1 << LSB_CUTOFF],
    output logic signed [OUT_WIDTH-1:0]  y_r,
    output logic signed [OUT_WIDTH-1:0]  y_i
);

    localparam int unsigned PW = DATA_WIDTH + TWID_WIDTH + 2;
    localparam logic signed [PW-1:0] ROUND = PW'(1) << (SHIFT - 1);

    cplx_t                        ent;
    logic signed [TWID_WIDTH-1:0] w_r;
    logic signed [TWID_WIDTH-1:0] w_i;
    logic signed [PW-1:0]         p_r_d;
    logic signed [PW-1:0]         p_i_d;
    logic signed [PW-1:0]         p_r_q;
    logic signed [PW-1:0]         p_i_q;
    logic signed [PW-1:0]         s_r;
    logic signed [PW-1:0]         s_i;
    logic signed [DATA_WIDTH-1:0] x1_r_q;
    logic signed [DATA_WIDTH-1:0] x1_i_q;

    assign ent = rom[k[LSB_CUTOFF-1:0]];

    // Upper half of the bin range is the lower half rotated by -j.
    always_comb begin
        w_r = TWID_WIDTH'(ent.re);
        w_i = -TWID_WIDTH'(ent.im);
        if (k[LSB_CUTOFF]) begin
            w_r = -TWID_WIDTH'(ent.im);
            w_i = -TWID_WIDTH'(ent.re);
        end
    end

    always_comb begin
        p_r_d = PW'(x2_r) * PW'(w_r) - PW'(x2_i) * PW'(w_i);
        p_i_d = PW'(x2_r) * PW'(w_i) + PW'(x2_i) * PW'(w_r);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_r_q  <= '0;
            p_i_q  <= '0;
            x1_r_q <= '0;
            x1_i_q <= '0;
        end else begin
            p_r_q  <= p_r_d;
            p_i_q  <= p_i_d;
            x1_r_q <= x1_r;
            x1_i_q <= x1_i;
        end
    end

    assign s_r = (p_r_q + ROUND) >>> SHIFT;
    assign s_i = (p_i_q + ROUND) >>> SHIFT;

    // Result fits in 29 bits, so truncating the shifted product cannot lose sign.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_r <= '0;
            y_i <= '0;
        end else begin
            y_r <= OUT_WIDTH'(x1_r_q) + OUT_WIDTH'(s_r);
            y_i <= OUT_WIDTH'(x1_i_q) + OUT_WIDTH'(s_i);
        end
    end

endmodule

// File: rtl/recover_2n_fft.sv
// Recombines two 8192-point half-spectra into a 16384-point real FFT,
// eight bins per clock across two 4-lane columns, fixed 3-cycle latency.
module recover_2n_fft
    import recover_2n_fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 27,
    parameter int unsigned TWID_WIDTH = 16,
    parameter int unsigned LSB_CUTOFF = 12,
    parameter int unsigned SHIFT      = 15
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 valid,
    output logic                                 ready,
    input  logic [N_LANES-1:0][DATA_WIDTH-1:0]   x1_col1_r,
    input  logic [N_LANES-1:0][DATA_WIDTH-1:0]   x1_col1_i,
    input  logic [N_LANES-1:0][DATA_WIDTH-1:0]   x2_col1_r,
    input  logic [N_LANES-1:0][DATA_WIDTH-1:0]   x2_col1_i,
    input  logic [LSB_CUTOFF-2:0]                index_col_1,
    input  logic [N_LANES-1:0][DATA_WIDTH-1:0]   x1_col2_r,
    input  logic [N_LANES-1:0][DATA_WIDTH-1:0]   x1_col2_i,
    input  logic [N_LANES-1:0][DATA_WIDTH-1:0]   x2_col2_r,
    input  logic [N_LANES-1:0][DATA_WIDTH-1:0]   x2_col2_i,
    input  logic [LSB_CUTOFF-2:0]                index_col_2,
    output logic [N_LANES-1:0][OUT_WIDTH-1:0]    dataout_col1_r,
    output logic [N_LANES-1:0][OUT_WIDTH-1:0]    dataout_col1_i,
    output logic [LSB_CUTOFF-2:0]                output_index_col1,
    output logic [N_LANES-1:0][OUT_WIDTH-1:0]    dataout_col2_r,
    output logic [N_LANES-1:0][OUT_WIDTH-1:0]    dataout_col2_i,
    output logic [LSB_CUTOFF-2:0]                output_index_col2
);

    localparam int unsigned ROM_DEPTH = 1 << LSB_CUTOFF;
    localparam int unsigned IW        = LSB_CUTOFF - 1;

    // Shared quarter-wave table; every lane indexes it independently.
    cplx_t rom [ROM_DEPTH];

    for (genvar m = 0; m < ROM_DEPTH; m++) begin : g_rom
        assign rom[m] = rom_entry(m, ROM_DEPTH);
    end

    logic [LATENCY-1:0]                        valid_q;
    logic [LATENCY-1:0][1:0][IW-1:0]           idx_q;
    logic [1:0][N_LANES-1:0][DATA_WIDTH-1:0]   x1r_q;
    logic [1:0][N_LANES-1:0][DATA_WIDTH-1:0]   x1i_q;
    logic [1:0][N_LANES-1:0][DATA_WIDTH-1:0]   x2r_q;
    logic [1:0][N_LANES-1:0][DATA_WIDTH-1:0]   x2i_q;
    logic [1:0][N_LANES-1:0][OUT_WIDTH-1:0]    y_r;
    logic [1:0][N_LANES-1:0][OUT_WIDTH-1:0]    y_i;

    // Stage 1 input capture plus the index/valid delay line that tracks the lanes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            idx_q   <= '0;
            x1r_q   <= '0;
            x1i_q   <= '0;
            x2r_q   <= '0;
            x2i_q   <= '0;
        end else begin
            valid_q <= {valid_q[LATENCY-2:0], valid};
            idx_q   <= {idx_q[LATENCY-2:0], {index_col_2, index_col_1}};
            x1r_q   <= {x1_col2_r, x1_col1_r};
            x1i_q   <= {x1_col2_i, x1_col1_i};
            x2r_q   <= {x2_col2_r, x2_col1_r};
            x2i_q   <= {x2_col2_i, x2_col1_i};
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_col
        for (genvar l = 0; l < N_LANES; l++) begin : g_lane
            recover_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .TWID_WIDTH (TWID_WIDTH),
                .LSB_CUTOFF (LSB_CUTOFF),
                .SHIFT      (SHIFT)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .k     ({idx_q[0][c], 2'(l)}),
                .x1_r  (x1r_q[c][l]),
                .x1_i  (x1i_q[c][l]),
                .x2_r  (x2r_q[c][l]),
                .x2_i  (x2i_q[c][l]),
                .rom   (rom),
                .y_r   (y_r[c][l]),
                .y_i   (y_i[c][l])
            );
        end
    end

    assign ready             = valid_q[LATENCY-1];
    assign output_index_col1 = idx_q[LATENCY-1][0];
    assign output_index_col2 = idx_q[LATENCY-1][1];
    assign dataout_col1_r    = y_r[0];
    assign dataout_col1_i    = y_i[0];
    assign dataout_col2_r    = y_r[1];
    assign dataout_col2_i    = y_i[1];

endmodule

// File: tb/tb_recover_2n_fft.sv
// Directed and full-frame checks of recover_2n_fft against a bench-side
// floating-point-derived twiddle model.
module tb_recover_2n_fft;

    localparam int  DW  = 27;
    localparam int  LAT = 3;
    localparam real PI  = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid = 1'b0;
    logic ready;
    logic [3:0][DW-1:0] x1_col1_r, x1_col1_i, x2_col1_r, x2_col1_i;
    logic [3:0][DW-1:0] x1_col2_r, x1_col2_i, x2_col2_r, x2_col2_i;
    logic [10:0] index_col_1, index_col_2, output_index_col1, output_index_col2;
    logic [3:0][31:0] dataout_col1_r, dataout_col1_i, dataout_col2_r, dataout_col2_i;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] fr_d [1025][2][4][4];
    logic [10:0]   fr_c [1025][2];

    always #5 clk = ~clk;

    recover_2n_fft #(
        .DATA_WIDTH (27),
        .TWID_WIDTH (16),
        .LSB_CUTOFF (12),
        .SHIFT      (15)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .valid             (valid),
        .ready             (ready),
        .x1_col1_r         (x1_col1_r),
        .x1_col1_i         (x1_col1_i),
        .x2_col1_r         (x2_col1_r),
        .x2_col1_i         (x2_col1_i),
        .index_col_1       (index_col_1),
        .x1_col2_r         (x1_col2_r),
        .x1_col2_i         (x1_col2_i),
        .x2_col2_r         (x2_col2_r),
        .x2_col2_i         (x2_col2_i),
        .index_col_2       (index_col_2),
        .dataout_col1_r    (dataout_col1_r),
        .dataout_col1_i    (dataout_col1_i),
        .output_index_col1 (output_index_col1),
        .dataout_col2_r    (dataout_col2_r),
        .dataout_col2_i    (dataout_col2_i),
        .output_index_col2 (output_index_col2)
    );

    function automatic longint twid_q15(input real v);
        longint r;
        r = longint'($rtoi(v * 32768.0 + 0.5));
        return (r > 32767) ? 64'sd32767 : r;
    endfunction

    function automatic void model(input int k, input longint x1r, input longint x1i,
                                  input longint x2r, input longint x2i,
                                  output longint yr, output longint yi);
        real    ang;
        longint c, s, wr, wi, pr, pim;
        ang = 2.0 * PI * real'(k % 4096) / 16384.0;
        c = twid_q15($cos(ang));
        s = twid_q15($sin(ang));
        if (k >= 4096) begin
            wr = -s;
            wi = -c;
        end else begin
            wr = c;
            wi = -s;
        end
        pr  = x2r * wr - x2i * wi;
        pim = x2r * wi + x2i * wr;
        yr  = x1r + ((pr + 64'sd16384) >>> 15);
        yi  = x1i + ((pim + 64'sd16384) >>> 15);
    endfunction

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'(signed'(v));
    endfunction

    task automatic clear_inputs();
        x1_col1_r = '0; x1_col1_i = '0; x2_col1_r = '0; x2_col1_i = '0;
        x1_col2_r = '0; x1_col2_i = '0; x2_col2_r = '0; x2_col2_i = '0;
        index_col_1 = '0;
        index_col_2 = '0;
        valid = 1'b0;
    endtask

    // One valid beat; returns ready as seen one cycle before the result is due.
    task automatic pulse(output logic early);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        early = ready;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            for (int l = 0; l < 4; l++) begin
                x1_col1_r[l] = DW'($urandom); x1_col1_i[l] = DW'($urandom);
                x2_col1_r[l] = DW'($urandom); x2_col1_i[l] = DW'($urandom);
                x1_col2_r[l] = DW'($urandom); x1_col2_i[l] = DW'($urandom);
                x2_col2_r[l] = DW'($urandom); x2_col2_i[l] = DW'($urandom);
            end
            index_col_1 = 11'($urandom);
            index_col_2 = 11'($urandom);
            valid = 1'b1;
            @(negedge clk);
            n_vec++;
            if (ready !== 1'b0) begin
                n_err++;
                $display("FAIL reset_ready: got %b expected 0", ready);
            end
            n_vec++;
            if ({dataout_col1_r, dataout_col1_i, dataout_col2_r, dataout_col2_i} !== '0) begin
                n_err++;
                $display("FAIL reset_data: got %h expected 0", dataout_col1_r);
            end
            n_vec++;
            if ({output_index_col1, output_index_col2} !== 22'd0) begin
                n_err++;
                $display("FAIL reset_index: got %0d/%0d expected 0/0",
                         output_index_col1, output_index_col2);
            end
        end
        rst_n = 1'b1;
        clear_inputs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_bin0();
        logic early;
        clear_inputs();
        x1_col1_r[0] = DW'(100);  x1_col1_i[0] = DW'(-5);
        x2_col1_r[0] = DW'(1000); x2_col1_i[0] = DW'(200);
        pulse(early);
        n_vec++;
        if (early !== 1'b0) begin
            n_err++;
            $display("FAIL bin0_ready_early: got %b expected 0", early);
        end
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL bin0_ready: got %b expected 1", ready);
        end
        n_vec++;
        if (dataout_col1_r[0] !== 32'(1100) || dataout_col1_i[0] !== 32'(195)) begin
            n_err++;
            $display("FAIL bin0_data: got (%0d,%0d) expected (1100,195)",
                     $signed(dataout_col1_r[0]), $signed(dataout_col1_i[0]));
        end
        n_vec++;
        if (output_index_col1 !== 11'd0) begin
            n_err++;
            $display("FAIL bin0_index: got %0d expected 0", output_index_col1);
        end
    endtask

    task automatic test_minus_j();
        logic early;
        clear_inputs();
        index_col_1 = 11'd1024;
        x2_col1_r[0] = DW'(1000);
        pulse(early);
        n_vec++;
        if (dataout_col1_r[0] !== 32'(0) || dataout_col1_i[0] !== 32'(-1000)) begin
            n_err++;
            $display("FAIL k4096_re_in: got (%0d,%0d) expected (0,-1000)",
                     $signed(dataout_col1_r[0]), $signed(dataout_col1_i[0]));
        end
        n_vec++;
        if (output_index_col1 !== 11'd1024) begin
            n_err++;
            $display("FAIL k4096_index: got %0d expected 1024", output_index_col1);
        end
        x2_col1_r[0] = DW'(0);
        x2_col1_i[0] = DW'(1000);
        pulse(early);
        n_vec++;
        if (dataout_col1_r[0] !== 32'(1000) || dataout_col1_i[0] !== 32'(0)) begin
            n_err++;
            $display("FAIL k4096_im_in: got (%0d,%0d) expected (1000,0)",
                     $signed(dataout_col1_r[0]), $signed(dataout_col1_i[0]));
        end
    endtask

    task automatic test_rounding();
        logic early;
        clear_inputs();
        index_col_1 = 11'd512;
        x2_col1_r[0] = DW'(1);
        pulse(early);
        n_vec++;
        if (dataout_col1_r[0] !== 32'(1) || dataout_col1_i[0] !== 32'(-1)) begin
            n_err++;
            $display("FAIL round_pos: got (%0d,%0d) expected (1,-1)",
                     $signed(dataout_col1_r[0]), $signed(dataout_col1_i[0]));
        end
        x2_col1_r[0] = DW'(-1);
        pulse(early);
        n_vec++;
        if (dataout_col1_r[0] !== 32'(-1) || dataout_col1_i[0] !== 32'(1)) begin
            n_err++;
            $display("FAIL round_neg: got (%0d,%0d) expected (-1,1)",
                     $signed(dataout_col1_r[0]), $signed(dataout_col1_i[0]));
        end
    endtask

    task automatic test_extremes();
        logic   early;
        longint yr, yi;
        logic [31:0] got_r, got_i;
        clear_inputs();
        index_col_1 = 11'd384;
        index_col_2 = 11'd384;
        for (int l = 0; l < 4; l++) begin
            x1_col1_r[l] = DW'(-(1 << 26)); x1_col1_i[l] = DW'(-(1 << 26));
            x2_col1_r[l] = DW'(-(1 << 26)); x2_col1_i[l] = DW'(-(1 << 26));
        end
        x1_col2_r = x1_col1_r; x1_col2_i = x1_col1_i;
        x2_col2_r = x2_col1_r; x2_col2_i = x2_col1_i;
        pulse(early);
        for (int c = 0; c < 2; c++) begin
            for (int l = 0; l < 4; l++) begin
                model(1536 + l, -(64'sd1 << 26), -(64'sd1 << 26), -(64'sd1 << 26),
                      -(64'sd1 << 26), yr, yi);
                got_r = (c == 0) ? dataout_col1_r[l] : dataout_col2_r[l];
                got_i = (c == 0) ? dataout_col1_i[l] : dataout_col2_i[l];
                n_vec++;
                if (got_r !== 32'(yr) || got_i !== 32'(yi)) begin
                    n_err++;
                    $display("FAIL extreme col%0d lane%0d: got (%0d,%0d) expected (%0d,%0d)",
                             c + 1, l, $signed(got_r), $signed(got_i), yr, yi);
                end
            end
        end
        clear_inputs();
        repeat (4) @(negedge clk);
    endtask

    // Two column-1-only beats then n_dual dual-column beats, checked as they emerge.
    task automatic test_frame(input int n_dual);
        int          total;
        int          ready_cnt;
        int          b;
        int          k;
        logic        exp_rdy;
        longint      yr, yi;
        logic [31:0] got_r, got_i;
        logic [10:0] got_idx;
        total = 2 + n_dual;
        ready_cnt = 0;
        for (int t = 0; t < total + LAT + 2; t++) begin
            b = t - LAT;
            exp_rdy = (b >= 0 && b < total);
            if (ready === 1'b1) ready_cnt++;
            n_vec++;
            if (ready !== exp_rdy) begin
                n_err++;
                $display("FAIL frame_ready cycle %0d: got %b expected %b", t, ready, exp_rdy);
            end
            if (exp_rdy) begin
                for (int c = 0; c < ((b >= 2) ? 2 : 1); c++) begin
                    got_idx = (c == 0) ? output_index_col1 : output_index_col2;
                    n_vec++;
                    if (got_idx !== fr_c[b][c]) begin
                        n_err++;
                        $display("FAIL frame_index beat %0d col%0d: got %0d expected %0d",
                                 b, c + 1, got_idx, fr_c[b][c]);
                    end
                    for (int l = 0; l < 4; l++) begin
                        k = int'(fr_c[b][c]) * 4 + l;
                        model(k, sx(fr_d[b][c][l][0]), sx(fr_d[b][c][l][1]),
                              sx(fr_d[b][c][l][2]), sx(fr_d[b][c][l][3]), yr, yi);
                        got_r = (c == 0) ? dataout_col1_r[l] : dataout_col2_r[l];
                        got_i = (c == 0) ? dataout_col1_i[l] : dataout_col2_i[l];
                        n_vec++;
                        if (got_r !== 32'(yr) || got_i !== 32'(yi)) begin
                            n_err++;
                            $display("FAIL frame_bin k=%0d: got (%0d,%0d) expected (%0d,%0d)",
                                     k, $signed(got_r), $signed(got_i), yr, yi);
                        end
                    end
                end
            end
            if (t < total) begin
                fr_c[t][0] = (t < 2) ? 11'(t * 1024) : 11'(t - 1);
                fr_c[t][1] = (t < 2) ? 11'd0 : 11'(1024 + t - 1);
                for (int c = 0; c < 2; c++)
                    for (int l = 0; l < 4; l++)
                        for (int p = 0; p < 4; p++)
                            fr_d[t][c][l][p] = (c == 1 && t < 2) ? '0 : DW'($urandom);
                for (int l = 0; l < 4; l++) begin
                    x1_col1_r[l] = fr_d[t][0][l][0]; x1_col1_i[l] = fr_d[t][0][l][1];
                    x2_col1_r[l] = fr_d[t][0][l][2]; x2_col1_i[l] = fr_d[t][0][l][3];
                    x1_col2_r[l] = fr_d[t][1][l][0]; x1_col2_i[l] = fr_d[t][1][l][1];
                    x2_col2_r[l] = fr_d[t][1][l][2]; x2_col2_i[l] = fr_d[t][1][l][3];
                end
                index_col_1 = fr_c[t][0];
                index_col_2 = fr_c[t][1];
                valid = 1'b1;
            end else begin
                clear_inputs();
            end
            @(negedge clk);
        end
        n_vec++;
        if (ready_cnt != total) begin
            n_err++;
            $display("FAIL frame_ready_count: got %0d expected %0d", ready_cnt, total);
        end
    endtask

    task automatic test_full_frame();
        test_frame(1023);
    endtask

    task automatic test_reset_mid_frame();
        clear_inputs();
        for (int t = 0; t < 5; t++) begin
            for (int l = 0; l < 4; l++) begin
                x1_col1_r[l] = DW'($urandom); x2_col1_r[l] = DW'($urandom);
                x1_col2_i[l] = DW'($urandom); x2_col2_i[l] = DW'($urandom);
            end
            index_col_1 = 11'(t + 7);
            index_col_2 = 11'(t + 900);
            valid = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_ready: got %b expected 0", ready);
        end
        n_vec++;
        if ({dataout_col1_r, dataout_col2_i, output_index_col1, output_index_col2} !== '0) begin
            n_err++;
            $display("FAIL midreset_flush: got %h/%0d expected 0/0",
                     dataout_col1_r, output_index_col1);
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        test_frame(6);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_bin0();
        test_minus_j();
        test_rounding();
        test_extremes();
        test_full_frame();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/recover_2n_fft.md
Name: recover_2n_fft

Overview:
- Final stage of a 16384-point real FFT built from two 8192-point complex FFTs.
- Per output bin: X[k] = X1[k] + W^k * X2[k], with W = exp(-j*2*pi/16384) and k in [0, 8192).
- X1 and X2 are the decoded even/odd half-spectra.
- Processes two 4-lane columns per clock (8 bins/cycle); full spectrum takes 1025 valid cycles.

Parameters:
- DATA_WIDTH, 27: signed two's-complement width of each input real/imag component.
- TWID_WIDTH, 16: signed twiddle width, Q1.15.
- LSB_CUTOFF, 12: log2 of quarter-wave twiddle table depth (4096 entries).
- SHIFT, 15: right shift applied to twiddle products (twiddle fractional bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- valid  in  1  input beat valid
- ready  out  1  output beat valid
- x1_col1_r, x1_col1_i, x2_col1_r, x2_col1_i  in  4 x DATA_WIDTH (packed [3:0][DATA_WIDTH-1:0])  column-1 lanes of X1/X2
- index_col_1  in  11  column-1 index c1
- x1_col2_r, x1_col2_i, x2_col2_r, x2_col2_i  in  4 x DATA_WIDTH  column-2 lanes
- index_col_2  in  11  column-2 index c2
- dataout_col1_r, dataout_col1_i  out  4 x 32  column-1 results
- output_index_col1  out  11  c1 delayed to match data
- dataout_col2_r, dataout_col2_i  out  4 x 32  column-2 results
- output_index_col2  out  11  c2 delayed to match data

Behaviour:
- Reset: rst_n sampled on posedge clk, active-low, synchronous. While low, every pipeline register, ready, all dataout_*, and output_index_* are 0.
- Bin index: lane l of a column with index c computes k = 4*c + l (13 bits).
- Twiddle, split k into q = k[12] and m = k[11:0]:
  - Table entries: C[m] = round(cos(2*pi*m/16384) * 2^15) and S[m] = round(sin(2*pi*m/16384) * 2^15), each clamped to 32767.
  - q = 0: Wr = C[m], Wi = -S[m].
  - q = 1 (multiply by -j): Wr = -S[m], Wi = -C[m].
- Per lane:
  - pr = X2r*Wr - X2i*Wi and pi = X2r*Wi + X2i*Wr, full precision (DATA_WIDTH + TWID_WIDTH + 2 bits).
  - Yr = X1r + ((pr + 2^(SHIFT-1)) >>> SHIFT); Yi likewise with pi. Shift is arithmetic.
  - Sign-extend Yr/Yi to 32 bits. Range is bounded to 29 bits, so no saturation is applied.
- Latency: fixed 3 clocks.
  - Stage 1: register inputs and indices.
  - Stage 2: twiddle lookup and multiply.
  - Stage 3: round, add, register outputs.
- Timing: ready = valid delayed 3 cycles. Data and output_index_* are aligned with ready.
- Pipeline is free-running, with no backpressure. Inputs with valid = 0 still propagate, but ready = 0 marks them invalid.
- Column 2 is computed every cycle. Its result is meaningful only when the source drove it; the first two beats of a frame carry column 1 only.
- Reset mid-frame: pipeline is flushed and ready drops to 0 on the next edge; a new frame starts cleanly.
- Continuous valid: one beat accepted per clock, no bubbles.

Decomposition:
- Package recover_2n_fft_pkg:
  - constants N_LANES = 4, OUT_WIDTH = 32, LATENCY = 3;
  - quarter-wave cos/sin ROM initialisation function (4096 x 16);
  - complex struct typedef.
- One sub-module, recover_lane: twiddle lookup, complex multiply, round and add for one lane.
  - Parameterised like the top.
  - Instantiated 8 times (2 columns x 4 lanes).

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with random inputs -> ready = 0, all outputs 0.
- Bin k = 0 (c1 = 0, lane 0): X1 = (100, -5), X2 = (1000, 200) -> (1100, 195) exactly, 3 cycles after valid; ready high the same cycle.
- Bin k = 4096 (c1 = 1024, lane 0, W = -j): X1 = 0, X2 = (1000, 0) -> (0, -1000). Repeat with X2 = (0, 1000) -> (1000, 0).
- Rounding: k = 2048 (W = 23170 - j23170), X1 = 0, X2 = (1, 0) -> pr = 23170, result (1, -1). Negative operand X2 = (-1, 0) -> (-1, 1).
- Full frame: 2 column-1-only beats then 1023 dual-column beats, random 27-bit data -> all 8192 bins match the bit-exact model; ready high for exactly 1025 cycles; output_index_* equal the delayed inputs.
- Extremes: X1 = X2 = -2^26 on all lanes with k = 1536 -> no wraparound; outputs match the model in 32 bits. Reset mid-frame, then restart -> clean results.
